// File: rtl/gate_sensor_pkg.sv
// gate_sensor_pkg: direction FSM state encoding and named sensor pair values ({A,B})
package gate_sensor_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6,
    ERR  = 3'd7
  } state_t;
  localparam logic [1:0] PAIR_CLEAR = 2'b00;
  localparam logic [1:0] PAIR_A     = 2'b10;
  localparam logic [1:0] PAIR_B     = 2'b01;
  localparam logic [1:0] PAIR_AB    = 2'b11;
endpackage

// File: rtl/pair_debouncer.sv
// pair_debouncer: 2-flop synchroniser plus whole-pair debounce of the gate sensors
module pair_debouncer
  import gate_sensor_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] raw,
  output logic [1:0] deb
);
  logic [1:0] meta, sync, prev;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // a pair that keeps changing restarts the count so only a stable value is accepted
  always_comb cnt_nxt = (sync == deb) ? '0 : (sync != prev) ? CNT_W'(1) : cnt + 1'b1;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      meta <= PAIR_CLEAR;
      sync <= PAIR_CLEAR;
      prev <= PAIR_CLEAR;
      deb  <= PAIR_CLEAR;
      cnt  <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
      cnt  <= cnt_nxt;
      if (cnt_nxt == CNT_W'(DEBOUNCE)) deb <= sync;
    end
endmodule

// File: rtl/gate_sensor_decoder.sv
// gate_sensor_decoder: turns debounced gate beam pairs into entry/exit pulses,
// rejecting partial, reversed and illegal passages
module gate_sensor_decoder
  import gate_sensor_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 3
) (
  input  logic Clock,
  input  logic Reset,
  input  logic SensorA,
  input  logic SensorB,
  output logic Increase,
  output logic Decrease,
  output logic Error,
  output logic Busy
);
  logic [1:0] deb;
  state_t state, state_nxt;
  logic inc_pend, dec_pend;
  pair_debouncer #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_deb (
    .Clock(Clock),
    .Reset(Reset),
    .raw  ({SensorA, SensorB}),
    .deb  (deb)
  );
  // each state holds on its own pair; the one pair two bits away is illegal
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = deb == PAIR_A ? EN1 : deb == PAIR_B ? EX1 : deb == PAIR_AB ? ERR : IDLE;
      EN1:  state_nxt = deb == PAIR_AB ? EN2 : deb == PAIR_CLEAR ? IDLE : deb == PAIR_B ? ERR : EN1;
      EN2:  state_nxt = deb == PAIR_B ? EN3 : deb == PAIR_A ? EN1 : deb == PAIR_CLEAR ? ERR : EN2;
      EN3:  state_nxt = deb == PAIR_CLEAR ? IDLE : deb == PAIR_AB ? EN2 : deb == PAIR_A ? ERR : EN3;
      EX1:  state_nxt = deb == PAIR_AB ? EX2 : deb == PAIR_CLEAR ? IDLE : deb == PAIR_A ? ERR : EX1;
      EX2:  state_nxt = deb == PAIR_A ? EX3 : deb == PAIR_B ? EX1 : deb == PAIR_CLEAR ? ERR : EX2;
      EX3:  state_nxt = deb == PAIR_CLEAR ? IDLE : deb == PAIR_AB ? EX2 : deb == PAIR_B ? ERR : EX3;
      ERR:  state_nxt = deb == PAIR_CLEAR ? IDLE : ERR;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state    <= IDLE;
      inc_pend <= 1'b0;
      dec_pend <= 1'b0;
      Increase <= 1'b0;
      Decrease <= 1'b0;
      Error    <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      inc_pend <= state == EN3 && state_nxt == IDLE;
      dec_pend <= state == EX3 && state_nxt == IDLE;
      Increase <= inc_pend;
      Decrease <= dec_pend;
      Error    <= state_nxt == ERR;
      Busy     <= state_nxt != IDLE;
    end
endmodule

// File: tb/tb_gate_sensor_decoder.sv
// tb_gate_sensor_decoder: directed passage table, corner sequences and a random
// run compared every cycle against a path-position reference model
module tb_gate_sensor_decoder;
  localparam int DEBOUNCE = 4;
  logic Clock = 1'b0, Reset = 1'b1, SensorA = 1'b0, SensorB = 1'b0;
  logic Increase, Decrease, Error, Busy;
  int checks = 0, errors = 0;
  gate_sensor_decoder #(.DEBOUNCE(DEBOUNCE), .CNT_W(3)) dut (
    .Clock(Clock), .Reset(Reset), .SensorA(SensorA), .SensorB(SensorB),
    .Increase(Increase), .Decrease(Decrease), .Error(Error), .Busy(Busy)
  );
  always #5 Clock = ~Clock;
  // model: a passage is a walk along a fixed path of pairs, one step at a time
  logic [1:0] pe [5];
  logic [1:0] px [5];
  logic [1:0] m_s1 = 0, m_sync = 0, m_deb = 0;
  logic [1:0] win [DEBOUNCE];
  int m_dir = 0, m_pos = 0;
  bit m_err = 0, m_pend_i = 0, m_pend_d = 0, m_inc = 0, m_dec = 0;
  function automatic logic [1:0] pv(input int dir, input int i);
    return dir == 1 ? pe[i] : px[i];
  endfunction
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_s1 = 0; m_sync = 0; m_deb = 0;
      for (int i = 0; i < DEBOUNCE; i++) win[i] = 0;
      m_dir = 0; m_pos = 0; m_err = 0;
      m_pend_i = 0; m_pend_d = 0; m_inc = 0; m_dec = 0;
    end else begin
      bit same;
      m_inc = m_pend_i; m_dec = m_pend_d;
      m_pend_i = 0; m_pend_d = 0;
      if (m_err) begin
        if (m_deb == 2'b00) m_err = 0;
      end else if (m_dir == 0) begin
        if (m_deb == pe[1]) begin m_dir = 1; m_pos = 1; end
        else if (m_deb == px[1]) begin m_dir = 2; m_pos = 1; end
        else if (m_deb != 2'b00) m_err = 1;
      end else if (m_deb != pv(m_dir, m_pos)) begin
        if (m_deb == pv(m_dir, m_pos + 1)) m_pos++;
        else if (m_deb == pv(m_dir, m_pos - 1)) m_pos--;
        else begin m_err = 1; m_dir = 0; m_pos = 0; end
        if (m_pos == 4) begin
          m_pend_i = m_dir == 1; m_pend_d = m_dir == 2; m_dir = 0; m_pos = 0;
        end else if (m_pos == 0) m_dir = 0;
      end
      for (int i = DEBOUNCE - 1; i > 0; i--) win[i] = win[i-1];
      win[0] = m_sync;
      same = 1;
      for (int i = 0; i < DEBOUNCE; i++) same &= (win[i] == m_sync);
      if (same && m_sync != m_deb) m_deb = m_sync;
      m_sync = m_s1;
      m_s1 = {SensorA, SensorB};
    end
  end
  always @(negedge Clock) begin
    logic [3:0] want;
    want = {m_inc, m_dec, m_err, (m_dir != 0) || m_err};
    checks++;
    if ({Increase, Decrease, Error, Busy} !== want) begin
      errors++;
      $display("FAIL model t=%0t inc/dec/err/busy got %b want %b", $time,
               {Increase, Decrease, Error, Busy}, want);
    end
  end
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask
  task automatic apply(input logic [1:0] r, input int n, output int ni, output int nd);
    {SensorA, SensorB} = r;
    ni = 0; nd = 0;
    repeat (n) begin
      @(negedge Clock);
      ni += int'(Increase);
      nd += int'(Decrease);
    end
  endtask
  typedef struct {
    logic [1:0] raw;
    int hold;
    int inc;
    int dec;
    logic err;
    logic busy;
  } vec_t;
  vec_t tbl [17];
  initial begin
    int ni, nd, ti, lat;
    pe = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    px = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    tbl[0]  = '{2'b00, 10, 0, 0, 1'b0, 1'b0};
    tbl[1]  = '{2'b10, 10, 0, 0, 1'b0, 1'b1};
    tbl[2]  = '{2'b11, 10, 0, 0, 1'b0, 1'b1};
    tbl[3]  = '{2'b01, 10, 0, 0, 1'b0, 1'b1};
    tbl[4]  = '{2'b00, 10, 1, 0, 1'b0, 1'b0};
    tbl[5]  = '{2'b01, 10, 0, 0, 1'b0, 1'b1};
    tbl[6]  = '{2'b11, 10, 0, 0, 1'b0, 1'b1};
    tbl[7]  = '{2'b10, 10, 0, 0, 1'b0, 1'b1};
    tbl[8]  = '{2'b00, 10, 0, 1, 1'b0, 1'b0};
    tbl[9]  = '{2'b10, 10, 0, 0, 1'b0, 1'b1};
    tbl[10] = '{2'b11, 10, 0, 0, 1'b0, 1'b1};
    tbl[11] = '{2'b10, 10, 0, 0, 1'b0, 1'b1};
    tbl[12] = '{2'b00, 10, 0, 0, 1'b0, 1'b0};
    tbl[13] = '{2'b10, 10, 0, 0, 1'b0, 1'b1};
    tbl[14] = '{2'b01, 10, 0, 0, 1'b1, 1'b1};
    tbl[15] = '{2'b01, 10, 0, 0, 1'b1, 1'b1};
    tbl[16] = '{2'b00, 10, 0, 0, 1'b0, 1'b0};
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset_outputs", int'({Increase, Decrease, Error, Busy}), 0);
    #1 Reset = 1'b1;
    apply(2'b00, 20, ni, nd);
    chk("idle_inc", ni, 0);
    chk("idle_dec", nd, 0);
    chk("idle_busy", int'(Busy), 0);
    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].raw, tbl[i].hold, ni, nd);
      chk($sformatf("vec%0d_inc", i), ni, tbl[i].inc);
      chk($sformatf("vec%0d_dec", i), nd, tbl[i].dec);
      chk($sformatf("vec%0d_err", i), int'(Error), int'(tbl[i].err));
      chk($sformatf("vec%0d_busy", i), int'(Busy), int'(tbl[i].busy));
    end
    apply(2'b10, 10, ni, nd);
    apply(2'b11, 10, ni, nd);
    apply(2'b01, 10, ni, nd);
    {SensorA, SensorB} = 2'b00;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clock);
      #1;
      if (Increase) begin lat = k; break; end
    end
    chk("entry_latency", lat, 8);
    apply(2'b00, 10, ni, nd);
    apply(2'b10, 10, ni, nd);
    apply(2'b11, 2, ni, nd);
    apply(2'b10, 10, ni, nd);
    chk("glitch_err", int'(Error), 0);
    chk("glitch_busy", int'(Busy), 1);
    ti = 0;
    apply(2'b11, 10, ni, nd); ti += ni;
    apply(2'b01, 10, ni, nd); ti += ni;
    apply(2'b00, 10, ni, nd); ti += ni;
    chk("glitch_entry_inc", ti, 1);
    apply(2'b10, 10, ni, nd);
    apply(2'b11, 10, ni, nd);
    apply(2'b01, 10, ni, nd);
    #1 Reset = 1'b0;
    {SensorA, SensorB} = 2'b00;
    #1 chk("midop_reset_outputs", int'({Increase, Decrease, Error, Busy}), 0);
    repeat (3) @(negedge Clock);
    #1 Reset = 1'b1;
    apply(2'b00, 20, ni, nd);
    chk("midop_no_inc", ni, 0);
    ti = 0;
    apply(2'b10, 10, ni, nd); ti += ni;
    apply(2'b11, 10, ni, nd); ti += ni;
    apply(2'b01, 10, ni, nd); ti += ni;
    apply(2'b00, 10, ni, nd); ti += ni;
    chk("after_reset_inc", ti, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #1 Reset = 1'b0;
        @(negedge Clock);
        #1 Reset = 1'b1;
      end
      apply(2'($urandom_range(0, 3)), int'($urandom_range(1, 12)), ni, nd);
    end
    apply(2'b00, 12, ni, nd);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
